rvvi_rx_packer: RTL and testbench

- Byte-to-word packer between the Ethernet receive MAC's byte stream and the RVVI AXI read-side word stream consumed by the trigger scanner and other RVVI frame consumers.
- Packs received bytes into 32-bit little-endian words with lane strobes and a last flag.
- Bounds frame length and closes bad frames cleanly, since the downstream word interface has no backpressure.
- Keeps saturating good-frame and dropped-frame counters for debug.

---
 rtl/rvvi_rx_packer.sv | 136 +++++++++++++
 tb/tb_rvvi_rx_packer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rvvi_rx_packer.sv
// Packs the receive MAC byte stream into 32-bit little-endian RVVI words with lane strobes
// and a last flag, bounding frame length and closing errored frames for a consumer that cannot stall.
module rvvi_rx_packer #(
  parameter int unsigned MAX_WORDS = 384,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       RxData,
  input  logic             RxValid,
  input  logic             RxLast,
  input  logic             RxError,
  output logic [31:0]      RvviAxiRdata,
  output logic [3:0]       RvviAxiRstrb,
  output logic             RvviAxiRlast,
  output logic             RvviAxiRvalid,
  output logic [CNT_W-1:0] FrameCount,
  output logic [CNT_W-1:0] DropCount
);

  localparam int unsigned WC_W = $clog2(MAX_WORDS + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PACK    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t          state;
  logic [1:0]      lane;
  logic [WC_W-1:0] wordCnt;
  logic [31:0]     partial;

  logic [1:0]      curLane;
  logic [31:0]     packedWord;
  logic [WC_W-1:0] curWords;
  logic [WC_W-1:0] nextWords;
  logic            emitWord;
  logic [3:0]      laneStrb;

  // A byte seen in IDLE always opens a fresh frame, regardless of leftover packing state.
  always_comb begin
    curLane    = 2'd0;
    curWords   = '0;
    packedWord = 32'(RxData);
    if (state == PACK) begin
      curLane    = lane;
      curWords   = wordCnt;
      packedWord = partial | (32'(RxData) << {curLane, 3'b000});
    end
    nextWords = curWords + WC_W'(1);
    emitWord  = (curLane == 2'd3) || RxLast;
    case (curLane)
      2'd0:    laneStrb = 4'b0001;
      2'd1:    laneStrb = 4'b0011;
      2'd2:    laneStrb = 4'b0111;
      default: laneStrb = 4'b1111;
    endcase
  end

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] cnt);
    return (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);
  endfunction

  // Frame state machine; the word outputs default to an idle zero word every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      lane          <= 2'd0;
      wordCnt       <= '0;
      partial       <= 32'd0;
      RvviAxiRdata  <= 32'd0;
      RvviAxiRstrb  <= 4'd0;
      RvviAxiRlast  <= 1'b0;
      RvviAxiRvalid <= 1'b0;
      FrameCount    <= '0;
      DropCount     <= '0;
    end else begin
      RvviAxiRdata  <= 32'd0;
      RvviAxiRstrb  <= 4'd0;
      RvviAxiRlast  <= 1'b0;
      RvviAxiRvalid <= 1'b0;
      case (state)
        IDLE, PACK: begin
          if (RxValid) begin
            if (RxError) begin
              // Only a frame the consumer has already seen needs an empty closing word.
              if (curWords != '0) begin
                RvviAxiRvalid <= 1'b1;
                RvviAxiRlast  <= 1'b1;
              end
              DropCount <= satInc(DropCount);
              lane      <= 2'd0;
              partial   <= 32'd0;
              wordCnt   <= '0;
              state     <= RxLast ? IDLE : DISCARD;
            end else if (emitWord) begin
              RvviAxiRvalid <= 1'b1;
              RvviAxiRdata  <= packedWord;
              RvviAxiRstrb  <= laneStrb;
              lane          <= 2'd0;
              partial       <= 32'd0;
              if (RxLast) begin
                RvviAxiRlast <= 1'b1;
                FrameCount   <= satInc(FrameCount);
                wordCnt      <= '0;
                state        <= IDLE;
              end else if (nextWords == WC_MAX) begin
                RvviAxiRlast <= 1'b1;
                DropCount    <= satInc(DropCount);
                wordCnt      <= '0;
                state        <= DISCARD;
              end else begin
                wordCnt <= nextWords;
                state   <= PACK;
              end
            end else begin
              partial <= packedWord;
              lane    <= curLane + 2'd1;
              wordCnt <= curWords;
              state   <= PACK;
            end
          end
        end
        DISCARD: begin
          if (RxValid && RxLast) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvvi_rx_packer.sv
// Directed bench for rvvi_rx_packer: a default-sized instance and a small instance
// (MAX_WORDS=4, CNT_W=2) share one byte stream; each has its own reset.
module tb_rvvi_rx_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetA, resetB;
  logic [7:0]  rxData;
  logic        rxValid, rxLast, rxError;

  logic [31:0] aRdata;
  logic [3:0]  aRstrb;
  logic        aRlast, aRvalid;
  logic [15:0] aFrameCount, aDropCount;

  logic [31:0] bRdata;
  logic [3:0]  bRstrb;
  logic        bRlast, bRvalid;
  logic [1:0]  bFrameCount, bDropCount;

  int total = 0;
  int bad   = 0;

  rvvi_rx_packer dutA (
    .clk(clk), .reset(resetA),
    .RxData(rxData), .RxValid(rxValid), .RxLast(rxLast), .RxError(rxError),
    .RvviAxiRdata(aRdata), .RvviAxiRstrb(aRstrb), .RvviAxiRlast(aRlast),
    .RvviAxiRvalid(aRvalid), .FrameCount(aFrameCount), .DropCount(aDropCount)
  );

  rvvi_rx_packer #(.MAX_WORDS(4), .CNT_W(2)) dutB (
    .clk(clk), .reset(resetB),
    .RxData(rxData), .RxValid(rxValid), .RxLast(rxLast), .RxError(rxError),
    .RvviAxiRdata(bRdata), .RvviAxiRstrb(bRstrb), .RvviAxiRlast(bRlast),
    .RvviAxiRvalid(bRvalid), .FrameCount(bFrameCount), .DropCount(bDropCount)
  );

  logic [7:0]  trig [0:19] = '{8'h43, 8'h68, 8'h11, 8'h11, 8'h02, 8'h45, 8'h54, 8'h16,
                               8'h00, 8'h00, 8'h54, 8'h8f, 8'h5c, 8'h00, 8'h74, 8'h72,
                               8'h69, 8'h67, 8'h69, 8'h6e};
  logic [31:0] trigWords [0:4] = '{32'h11116843, 32'h16544502, 32'h8f540000,
                                   32'h7274005c, 32'h6e696769};

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Word outputs packed as {valid, last, strb, data}.
  task automatic checkA(input string tag, input logic [31:0] d, input logic [3:0] s,
                        input logic l, input logic v);
    checkVal(tag, 64'({aRvalid, aRlast, aRstrb, aRdata}), 64'({v, l, s, d}));
  endtask

  task automatic checkB(input string tag, input logic [31:0] d, input logic [3:0] s,
                        input logic l, input logic v);
    checkVal(tag, 64'({bRvalid, bRlast, bRstrb, bRdata}), 64'({v, l, s, d}));
  endtask

  // Present one byte for one clock, then sample 1 time unit after the edge.
  task automatic sendByte(input logic [7:0] d, input logic last, input logic err);
    rxData  = d;
    rxValid = 1'b1;
    rxLast  = last;
    rxError = err;
    @(posedge clk);
    #1;
    rxValid = 1'b0;
    rxLast  = 1'b0;
    rxError = 1'b0;
    rxData  = 8'h00;
  endtask

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetA  = 1'b1;
    resetB  = 1'b1;
    rxData  = 8'h00;
    rxValid = 1'b0;
    rxLast  = 1'b0;
    rxError = 1'b0;
    #12;
    checkA("reset word", 32'h0, 4'h0, 1'b0, 1'b0);
    checkVal("reset counts", 64'({aFrameCount, aDropCount}), 64'd0);
    @(negedge clk);
    resetA = 1'b0;
    resetB = 1'b0;
    idleCycle();

    // Trigger frame: a word on every fourth byte, last only on the fifth word.
    for (int i = 0; i < 20; i++) begin
      sendByte(trig[i], i == 19, 1'b0);
      if (i % 4 == 3)
        checkA($sformatf("trig word%0d", i / 4), trigWords[i / 4], 4'hf, i == 19, 1'b1);
      else
        checkA($sformatf("trig quiet%0d", i), 32'h0, 4'h0, 1'b0, 1'b0);
    end
    checkVal("trig frames", 64'(aFrameCount), 64'd1);

    // Partial word with idle gaps.
    sendByte(8'h01, 1'b0, 1'b0);
    sendByte(8'h02, 1'b0, 1'b0);
    idleCycle();
    checkA("gap hold", 32'h0, 4'h0, 1'b0, 1'b0);
    sendByte(8'h03, 1'b0, 1'b0);
    sendByte(8'h04, 1'b0, 1'b0);
    checkA("partial word0", 32'h04030201, 4'hf, 1'b0, 1'b1);
    idleCycle();
    sendByte(8'h05, 1'b0, 1'b0);
    checkA("partial quiet", 32'h0, 4'h0, 1'b0, 1'b0);
    sendByte(8'h06, 1'b1, 1'b0);
    checkA("partial word1", 32'h00000605, 4'h3, 1'b1, 1'b1);
    checkVal("partial frames", 64'(aFrameCount), 64'd2);

    // Error on byte 6 after one word was emitted.
    for (int k = 1; k <= 9; k++) begin
      sendByte(8'(8'h20 + k), k == 9, k == 6);
      if (k == 4)      checkA("err word0", 32'h24232221, 4'hf, 1'b0, 1'b1);
      else if (k == 6) checkA("err close", 32'h0, 4'h0, 1'b1, 1'b1);
      else if (k > 6)  checkA($sformatf("err discard%0d", k), 32'h0, 4'h0, 1'b0, 1'b0);
    end
    checkVal("err counts", 64'({aFrameCount, aDropCount}), 64'({16'd2, 16'd1}));

    // Single-byte frame, then error on first byte discarding the following frame.
    sendByte(8'haa, 1'b1, 1'b0);
    checkA("single byte", 32'h000000aa, 4'h1, 1'b1, 1'b1);
    sendByte(8'hbb, 1'b0, 1'b1);
    checkA("first err quiet", 32'h0, 4'h0, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      sendByte(8'(k), k == 3, 1'b0);
      checkA($sformatf("discard%0d", k), 32'h0, 4'h0, 1'b0, 1'b0);
    end
    sendByte(8'hcc, 1'b1, 1'b0);
    checkA("after discard", 32'h000000cc, 4'h1, 1'b1, 1'b1);
    checkVal("pre-reset counts", 64'({aFrameCount, aDropCount}), 64'({16'd4, 16'd2}));

    // Reset mid-frame: async clear, next byte restarts at lane 0.
    sendByte(8'h55, 1'b0, 1'b0);
    sendByte(8'h66, 1'b0, 1'b0);
    resetA = 1'b1;
    #1;
    checkA("async reset word", 32'h0, 4'h0, 1'b0, 1'b0);
    checkVal("async reset counts", 64'({aFrameCount, aDropCount}), 64'd0);
    @(negedge clk);
    resetA = 1'b0;
    sendByte(8'h11, 1'b0, 1'b0);
    sendByte(8'h22, 1'b0, 1'b0);
    sendByte(8'h33, 1'b0, 1'b0);
    sendByte(8'h44, 1'b1, 1'b0);
    checkA("post reset word", 32'h44332211, 4'hf, 1'b1, 1'b1);
    checkVal("post reset counts", 64'({aFrameCount, aDropCount}), 64'({16'd1, 16'd0}));

    // Truncation on the small instance: 18-byte frame, then exactly 16 bytes.
    @(negedge clk);
    resetB = 1'b1;
    #1;
    resetB = 1'b0;
    idleCycle();
    for (int k = 1; k <= 18; k++) begin
      sendByte(8'(k), k == 18, 1'b0);
      if (k == 12)      checkB("trunc word2", 32'h0c0b0a09, 4'hf, 1'b0, 1'b1);
      else if (k == 16) checkB("trunc word3", 32'h100f0e0d, 4'hf, 1'b1, 1'b1);
      else if (k > 16)  checkB($sformatf("trunc ignore%0d", k), 32'h0, 4'h0, 1'b0, 1'b0);
    end
    checkVal("trunc counts", 64'({bFrameCount, bDropCount}), 64'({2'd0, 2'd1}));
    for (int k = 1; k <= 16; k++) begin
      sendByte(8'(k), k == 16, 1'b0);
    end
    checkB("exact max word", 32'h100f0e0d, 4'hf, 1'b1, 1'b1);
    checkVal("exact max counts", 64'({bFrameCount, bDropCount}), 64'({2'd1, 2'd1}));

    // Saturation of the 2-bit counters.
    sendByte(8'h01, 1'b1, 1'b0);
    sendByte(8'h02, 1'b1, 1'b0);
    checkVal("frame reach max", 64'(bFrameCount), 64'd3);
    sendByte(8'h03, 1'b1, 1'b0);
    checkVal("frame saturate", 64'(bFrameCount), 64'd3);
    sendByte(8'h04, 1'b1, 1'b1);
    checkB("err last quiet", 32'h0, 4'h0, 1'b0, 1'b0);
    sendByte(8'h05, 1'b1, 1'b1);
    checkVal("drop reach max", 64'(bDropCount), 64'd3);
    sendByte(8'h06, 1'b1, 1'b1);
    checkVal("drop saturate", 64'({bFrameCount, bDropCount}), 64'({2'd3, 2'd3}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
